sprite_blitter: RTL
===================

# sprite_blitter

Parametrised sprite renderer for the chess VGA path. It draws one selectable piece sprite from a shared multi-sprite palette-index ROM at an arbitrary screen position, and treats one palette index as transparent. Position, sprite select and highlight are latched once per frame, and an optional blinking highlight border marks the selected piece. It sits between the VGA controller (DrawX/DrawY/blank) and the palette/compositor, and drives an external synchronous ROM.

## Interface

Parameters:
- SPRITE_W, 55, sprite width in pixels
- SPRITE_H, 55, sprite height in pixels
- SPRITE_COUNT, 12, sprites stored back-to-back in ROM
- ADDR_W, 16, ROM address width; must be ≥ clog2(SPRITE_COUNT·SPRITE_W·SPRITE_H)
- PIX_W, 2, palette index width
- ROM_LATENCY, 1, ROM read latency in cycles (≥1)
- TRANSPARENT_IDX, 0, palette index treated as see-through
- BLINK_FRAMES, 30, frames per highlight blink half-period

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video
- sprite_x  in  10  sprite left edge
- sprite_y  in  10  sprite top edge
- sprite_id  in  clog2(SPRITE_COUNT)  sprite select
- sprite_en  in  1  draw enable
- highlight  in  1  request highlight border
- rom_addr  out  ADDR_W  ROM address, registered
- rom_q  in  PIX_W  ROM data, valid ROM_LATENCY cycles after rom_addr
- pix_index  out  PIX_W  palette index of the output pixel
- pix_hit  out  1  1 = sprite pixel is opaque; the compositor shows pix_index
- pix_blank  out  1  blank delayed to align with pix_index/pix_hit

## Operation

- Frame start is DrawX==0 && DrawY==0, sampled on the posedge. On frame start, shadow registers latch sprite_x, sprite_y, sprite_id, sprite_en and highlight. All drawing uses the shadow values, so there is no mid-frame tearing.
- Stage 0 (registered):
  - lx = DrawX − sx and ly = DrawY − sy, in 11-bit arithmetic.
  - inside = en && blank && DrawX ≥ sx && lx < SPRITE_W && DrawY ≥ sy && ly < SPRITE_H && id < SPRITE_COUNT.
  - Comparisons are 11-bit. A sprite crossing x=640 or y=480 is clipped, not wrapped.
  - border = inside && (lx==0 || lx==SPRITE_W−1 || ly==0 || ly==SPRITE_H−1).
- Stage 1: rom_addr = id·SPRITE_W·SPRITE_H + ly·SPRITE_W + lx, computed with constant multiplies and no divider. When not inside, rom_addr = 0.
- Stage 1+ROM_LATENCY: inside, border and blank are delay-matched through a shift pipeline, and the output registers are updated:
  - pix_hit = inside && rom_q != TRANSPARENT_IDX.
  - pix_index = rom_q if pix_hit, else 0.
- Frame counter: counts frame starts 0..BLINK_FRAMES−1. When it wraps, blink phase toggles.
- Reset: all outputs are 0, the shadow registers, pipeline, frame counter and phase are 0, and the shadow enable is 0, so nothing is drawn until the first frame start after reset.

## Timing

- Latency L = ROM_LATENCY + 2 cycles, measured from a DrawX/DrawY sample to the matching pix_index/pix_hit/pix_blank.
- Throughput: one pixel per cycle, no stalls.
- pix_blank equals blank delayed by exactly L cycles.
- Changes to sprite_* or highlight take effect only from the frame start that follows them.
- If a frame start and an input change occur in the same cycle, the value present at that edge is latched.
- Reset asserted mid-line clears the pipeline immediately. Outputs stay 0 until the first frame start after reset deasserts.

## Configuration

- SPRITE_HIGHLIGHT_EN defined:
  - When the shadow highlight is 1 and blink phase is 1, border pixels are forced to pix_hit = 1 and pix_index = all ones (2^PIX_W − 1), regardless of rom_q.
  - The frame counter and phase logic are present.
- SPRITE_HIGHLIGHT_EN undefined:
  - The highlight port is accepted but ignored.
  - The frame counter, phase and border logic are not instantiated.
  - Output equals the opaque-pixel rule only.

## Test plan

- Reset mid-frame: assert reset at DrawX=300 → pix_hit=0, pix_index=0, rom_addr=0 every cycle until the next frame start after release.
- Sprite at (100,50), id=3, ROM_LATENCY=1: DrawX=100, DrawY=50 → rom_addr = 3·3025 + 0 = 9075 one cycle later; pix_hit/pix_index with rom_q at cycle 3. DrawX=154, DrawY=104 → rom_addr = 9075 + 54·55 + 54 = 12099.
- Transparency: rom_q = TRANSPARENT_IDX inside the box → pix_hit=0, pix_index=0; rom_q=2 → pix_hit=1, pix_index=2.
- Clipping: sprite_x=600 → DrawX 600..639 hit as per ROM; no hit on the next line at DrawX 0..14.
- Frame latching: change sprite_x 100→200 at DrawY=200 → rows ≥200 still drawn at x=100; next frame drawn at x=200.
- With SPRITE_HIGHLIGHT_EN, BLINK_FRAMES=2, highlight=1: border pixels show pix_index=3, pix_hit=1 in frames 2–3, normal in frames 0–1 and 4–5. Without the macro: never forced.

Source files
------------

// File: rtl/sprite_blitter.sv
// sprite_blitter: draws one selectable sprite from a shared multi-sprite palette-index ROM at
// an arbitrary screen position. One palette index is treated as transparent.
//
// Sprite position, select, enable and highlight are captured into shadow registers at frame
// start (DrawX==0 && DrawY==0), so a frame is always drawn with one consistent set of values.
//
// Ports:
//   vga_clk, reset          pixel clock, asynchronous active-high reset
//   DrawX, DrawY, blank     VGA scan position and active-video flag (1 = active)
//   sprite_x, sprite_y      sprite top-left corner
//   sprite_id, sprite_en    sprite select and draw enable
//   highlight               request blinking highlight border
//   rom_addr / rom_q        external synchronous ROM (rom_q valid ROM_LATENCY cycles later)
//   pix_index, pix_hit      output palette index and opaque flag
//   pix_blank               blank delayed to line up with pix_index/pix_hit
//
// Latency from a DrawX/DrawY sample to the matching outputs is ROM_LATENCY + 2 cycles.
//
// Optional feature macro: SPRITE_HIGHLIGHT_EN. When defined, a frame counter toggles a blink
// phase every BLINK_FRAMES frame starts, and while the shadow highlight and the phase are both
// set, border pixels are forced opaque with the all-ones palette index. When undefined, the
// highlight input is ignored and no counter/border logic is built.
module sprite_blitter #(
    parameter int unsigned SPRITE_W        = 55,
    parameter int unsigned SPRITE_H        = 55,
    parameter int unsigned SPRITE_COUNT    = 12,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned PIX_W           = 2,
    parameter int unsigned ROM_LATENCY     = 1,
    parameter int unsigned TRANSPARENT_IDX = 0,
    parameter int unsigned BLINK_FRAMES    = 30
) (
    input  logic                            vga_clk,
    input  logic                            reset,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic                            blank,
    input  logic [9:0]                      sprite_x,
    input  logic [9:0]                      sprite_y,
    input  logic [$clog2(SPRITE_COUNT)-1:0] sprite_id,
    input  logic                            sprite_en,
    input  logic                            highlight,
    output logic [ADDR_W-1:0]               rom_addr,
    input  logic [PIX_W-1:0]                rom_q,
    output logic [PIX_W-1:0]                pix_index,
    output logic                            pix_hit,
    output logic                            pix_blank
);

    localparam int unsigned ID_W       = $clog2(SPRITE_COUNT);
    localparam int unsigned SPRITE_PIX = SPRITE_W * SPRITE_H;
    // Delay stages from the stage-0 registers to the cycle where rom_q is valid.
    localparam int unsigned DLY        = ROM_LATENCY + 1;

    // Shadow registers.
    logic            frame_start;
    logic [9:0]      sx_q, sx_d, sy_q, sy_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            en_q, en_d;

    // Stage 0.
    logic [10:0]     lx_q, lx_d, ly_q, ly_d;
    logic [ID_W-1:0] id0_q;
    logic            inside0_q, inside_d;
    logic            blank0_q;

    // Stage 1 and delay-match pipeline.
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DLY-1:0]    in_pipe_q, in_pipe_d;
    logic [DLY-1:0]    blank_pipe_q, blank_pipe_d;

    // Output registers.
    logic [PIX_W-1:0] pix_index_q, pix_index_d;
    logic             pix_hit_q, pix_hit_d;
    logic             pix_blank_q;

`ifdef SPRITE_HIGHLIGHT_EN
    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic             hl_q, hl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             force_d, force0_q;
    logic [DLY-1:0]   force_pipe_q, force_pipe_d;
`else
    localparam int unsigned unused_blink_frames = BLINK_FRAMES;
    logic unused_highlight;
    assign unused_highlight = highlight;
`endif

    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

    // Use the incoming values on the frame-start cycle so the whole frame sees one setting.
    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        id_d = id_q;
        en_d = en_q;
        if (frame_start) begin
            sx_d = sprite_x;
            sy_d = sprite_y;
            id_d = sprite_id;
            en_d = sprite_en;
        end
    end

`ifdef SPRITE_HIGHLIGHT_EN
    always_comb begin
        hl_d    = hl_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_start) begin
            hl_d = highlight;
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end
`endif

    // Stage 0: sprite-local coordinates and box test. The >= checks reject the wrapped
    // differences, so sprites running off the right/bottom edge are clipped.
    always_comb begin
        lx_d     = {1'b0, DrawX} - {1'b0, sx_d};
        ly_d     = {1'b0, DrawY} - {1'b0, sy_d};
        inside_d = en_d && blank
                   && ({1'b0, DrawX} >= {1'b0, sx_d}) && (lx_d < 11'(SPRITE_W))
                   && ({1'b0, DrawY} >= {1'b0, sy_d}) && (ly_d < 11'(SPRITE_H))
                   && (32'(id_d) < SPRITE_COUNT);
`ifdef SPRITE_HIGHLIGHT_EN
        force_d  = inside_d && hl_d && phase_d
                   && ((lx_d == 11'd0) || (lx_d == 11'(SPRITE_W - 1))
                       || (ly_d == 11'd0) || (ly_d == 11'(SPRITE_H - 1)));
`endif
    end

    // Stage 1: ROM address with constant multiplies only.
    always_comb begin
        rom_addr_d = '0;
        if (inside0_q) begin
            rom_addr_d = ADDR_W'(32'(id0_q) * SPRITE_PIX + 32'(ly_q) * SPRITE_W + 32'(lx_q));
        end
        in_pipe_d    = {in_pipe_q[DLY-2:0], inside0_q};
        blank_pipe_d = {blank_pipe_q[DLY-2:0], blank0_q};
`ifdef SPRITE_HIGHLIGHT_EN
        force_pipe_d = {force_pipe_q[DLY-2:0], force0_q};
`endif
    end

    // Output stage: the last pipeline entry lines up with rom_q.
    always_comb begin
        pix_hit_d   = in_pipe_q[DLY-1] && (rom_q != PIX_W'(TRANSPARENT_IDX));
        pix_index_d = pix_hit_d ? rom_q : '0;
`ifdef SPRITE_HIGHLIGHT_EN
        if (force_pipe_q[DLY-1]) begin
            pix_hit_d   = 1'b1;
            pix_index_d = '1;
        end
`endif
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            sx_q         <= '0;
            sy_q         <= '0;
            id_q         <= '0;
            en_q         <= 1'b0;
            lx_q         <= '0;
            ly_q         <= '0;
            id0_q        <= '0;
            inside0_q    <= 1'b0;
            blank0_q     <= 1'b0;
            rom_addr_q   <= '0;
            in_pipe_q    <= '0;
            blank_pipe_q <= '0;
            pix_index_q  <= '0;
            pix_hit_q    <= 1'b0;
            pix_blank_q  <= 1'b0;
`ifdef SPRITE_HIGHLIGHT_EN
            hl_q         <= 1'b0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            force0_q     <= 1'b0;
            force_pipe_q <= '0;
`endif
        end else begin
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            id_q         <= id_d;
            en_q         <= en_d;
            lx_q         <= lx_d;
            ly_q         <= ly_d;
            id0_q        <= id_d;
            inside0_q    <= inside_d;
            blank0_q     <= blank;
            rom_addr_q   <= rom_addr_d;
            in_pipe_q    <= in_pipe_d;
            blank_pipe_q <= blank_pipe_d;
            pix_index_q  <= pix_index_d;
            pix_hit_q    <= pix_hit_d;
            pix_blank_q  <= blank_pipe_q[DLY-1];
`ifdef SPRITE_HIGHLIGHT_EN
            hl_q         <= hl_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            force0_q     <= force_d;
            force_pipe_q <= force_pipe_d;
`endif
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_index = pix_index_q;
    assign pix_hit   = pix_hit_q;
    assign pix_blank = pix_blank_q;

endmodule
